req_queue: RTL

- Per-requester request buffer that sits directly upstream of the access scheduler tree (the ASM/AST arbiter).
- Accepts data_width-bit request words from a producer (core / interconnect port) and holds them in a small FIFO.
- Presents the head word to one arbiter leaf as req/d_OUT.
- Retires the head word only when the arbiter grants that leaf (serv), so a losing requester keeps its request asserted until it wins.

---
 rtl/req_queue_pkg.sv | 15 +
 rtl/req_queue_if.sv | 31 +++
 rtl/req_queue_starve_mon.sv | 42 ++++
 rtl/req_queue.sv | 80 ++++++++
 4 files changed

// File: rtl/req_queue_pkg.sv
// Shared types and width helper for the request queue and the arbiter tree.
package req_queue_pkg;

  localparam int DATA_WIDTH = 132;

  typedef logic [DATA_WIDTH-1:0] req_word_t;

  function automatic int clog2(input int value);
    int r;
    r = 0;
    while ((1 << r) < value) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/req_queue_if.sv
// Producer/arbiter-side bundle of the request queue; slave = queue, master = environment.
interface req_queue_if
  import req_queue_pkg::*;
#(
  parameter int data_width = DATA_WIDTH,
  parameter int depth      = 4
);

  localparam int CW = clog2(depth + 1);

  logic                  push_valid;
  logic                  push_ready;
  logic [data_width-1:0] push_data;
  logic                  req;
  logic [data_width-1:0] d_OUT;
  logic                  serv;
  logic [CW-1:0]         count;
  logic                  serv_err;
  logic                  starve;

  modport slave (
    input  push_valid, push_data, serv,
    output push_ready, req, d_OUT, count, serv_err, starve
  );

  modport master (
    output push_valid, push_data, serv,
    input  push_ready, req, d_OUT, count, serv_err, starve
  );

endinterface

// File: rtl/req_queue_starve_mon.sv
// Age counter for an unserviced request; starve is registered and rises when the
// saturating count reaches starve_limit, clearing the cycle after a grant or req drop.
module req_queue_starve_mon
  import req_queue_pkg::*;
#(
  parameter int starve_limit = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic serv,
  output logic starve
);

  localparam int AW = clog2(starve_limit + 1);

  logic [AW-1:0] age_q, age_d;
  logic          starve_q;

  // Any grant while req is up is a pop, so serv alone is enough to clear.
  always_comb begin
    age_d = age_q;
    if (!req || serv) begin
      age_d = '0;
    end else if (age_q != AW'(starve_limit)) begin
      age_d = AW'(age_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      age_q    <= '0;
      starve_q <= 1'b0;
    end else begin
      age_q    <= age_d;
      starve_q <= (age_d == AW'(starve_limit));
    end
  end

  assign starve = starve_q;

endmodule

// File: rtl/req_queue.sv
// Per-requester FIFO feeding one arbiter leaf; head retires only on grant, 1-cycle push-to-req.
// push_ready = !full with no path from serv; optional starve monitor under REQ_QUEUE_STARVE_MON_EN.
module req_queue
  import req_queue_pkg::*;
#(
  parameter int data_width   = DATA_WIDTH,
  parameter int depth        = 4,
  parameter int starve_limit = 15
) (
  input logic       clk,
  input logic       rst,
  req_queue_if.slave q
);

  localparam int PW = clog2(depth);
  localparam int CW = clog2(depth + 1);

  logic [data_width-1:0] mem_q [depth];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  serv_err_q, serv_err_d;
  logic                  full, empty, push_fire, pop_fire;

  assign full      = (count_q == CW'(depth));
  assign empty     = (count_q == '0);
  assign push_fire = q.push_valid && !full;
  assign pop_fire  = q.serv && !empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    serv_err_d = serv_err_q || (q.serv && empty);
    if (push_fire) wr_ptr_d = PW'(wr_ptr_q + 1'b1);
    if (pop_fire)  rd_ptr_d = PW'(rd_ptr_q + 1'b1);
    if (push_fire && !pop_fire) count_d = CW'(count_q + 1'b1);
    if (pop_fire && !push_fire) count_d = CW'(count_q - 1'b1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      serv_err_q <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      serv_err_q <= serv_err_d;
    end
  end

  // Storage is not reset: an entry is only visible once count covers it.
  always_ff @(posedge clk) begin
    if (!rst && push_fire) mem_q[wr_ptr_q] <= q.push_data;
  end

  assign q.push_ready = !full;
  assign q.req        = !empty;
  assign q.d_OUT      = mem_q[rd_ptr_q];
  assign q.count      = count_q;
  assign q.serv_err   = serv_err_q;

`ifdef REQ_QUEUE_STARVE_MON_EN
  req_queue_starve_mon #(
    .starve_limit(starve_limit)
  ) u_starve_mon (
    .clk   (clk),
    .rst   (rst),
    .req   (!empty),
    .serv  (q.serv),
    .starve(q.starve)
  );
`else
  assign q.starve = 1'b0;
`endif

endmodule
